stage_ex: RTL and testbench
===========================

Name: stage_ex

Overview:
- MIPS execute stage. Consumes the ID/EX pipeline register fields produced by the decode stage (control bits, operands, sign-extended immediate, register addresses, PC).
- Computes the ALU result, resolves branches and jumps, and registers results into the EX/MEM pipeline register.
- Squashes wrong-path instructions after a taken control transfer, and supports stall and flush from the hazard logic.

Parameters:
- SQUASH_CNT, 1: number of valid instructions after a taken branch/jump that are converted to bubbles (0..3).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  ID/EX slot holds a real instruction.
- pc_ex  in  32  PC+4 of the instruction.
- aluOp  in  4  ALU operation (package encoding).
- isJump  in  1  control transfer instruction.
- isNotConditional  in  1  with isJump: unconditional jump.
- isEq  in  1  branch on equal (1) or not-equal (0).
- memWrite  in  1  store.
- memRead  in  1  load.
- wbi  in  2  writeback control, passed through.
- aluSrc  in  1  operand B select: 1 = extendedInstr, 0 = reg2.
- reg1  in  32  rs value.
- reg2  in  32  rt value.
- extendedInstr  in  32  sign-extended immediate.
- regAddr1  in  5  rt field.
- regAddr2  in  5  rd field.
- regDst  in  1  destination select: 1 = regAddr2, 0 = regAddr1.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  insert a bubble into EX/MEM.
- fwdA  in  2  operand A forward select (see Optional Feature).
- fwdB  in  2  operand B forward select.
- fwdMem  in  32  EX/MEM forwarded value.
- fwdWb  in  32  MEM/WB forwarded value.
- aluResult_mem  out  32  registered ALU result.
- storeData_mem  out  32  registered rt value, used as store data.
- writeAddr_mem  out  5  registered destination register.
- memWrite_mem  out  1  registered memWrite, gated by validity.
- memRead_mem  out  1  registered memRead, gated by validity.
- wbi_mem  out  2  registered wbi, gated by validity.
- valid_mem  out  1  EX/MEM slot valid.
- branchTaken  out  1  one-cycle pulse: redirect fetch.
- branchTarget  out  32  redirect address, valid with branchTaken.

Behaviour:
- Reset: all outputs 0, squash counter 0.
- Latency: 1 cycle from ID/EX inputs to registered outputs. No combinational input-to-output path.
- Operand A = reg1. Operand B = extendedInstr if aluSrc, else reg2.
- ALU (package encoding):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift B by extendedInstr[10:6].
  - 11 LUI: {B[15:0],16'h0}.
  - 12..15 produce 0.
  - Arithmetic is mod 2^32; overflow is ignored.
- Destination: writeAddr = regDst ? regAddr2 : regAddr1.
- Branch condition:
  - take = isJump & (isNotConditional | (isEq ? A==B_reg : A!=B_reg)).
  - B_reg is always reg2, independent of aluSrc.
- Branch target:
  - Conditional: pc_ex + (extendedInstr<<2), mod 2^32.
  - Unconditional: {pc_ex[31:28], extendedInstr[25:0]... } is not available from the inputs, so the target is extendedInstr<<2 + pc_ex as well; decode supplies the offset.
- Effective validity: eff_valid = valid_in & (squash counter == 0).
- Cycle update:
  - If not stall and not flush: load the EX/MEM register. valid_mem <= eff_valid. memWrite_mem, memRead_mem and wbi_mem are zeroed when eff_valid is 0.
  - branchTaken <= eff_valid & take. When this pulse fires, the squash counter is loaded with SQUASH_CNT.
  - When valid_in & counter != 0, the counter decrements and the instruction becomes a bubble.
- flush (priority over stall):
  - valid_mem, memWrite_mem, memRead_mem, wbi_mem and branchTaken <= 0.
  - Data fields: don't care.
  - Squash counter cleared.
- stall:
  - All EX/MEM outputs hold.
  - branchTaken <= 0, so the pulse never repeats.
  - Squash counter holds.
- A taken branch while counter != 0 is itself squashed and produces no pulse.
- Bubbles (valid_in = 0) do not decrement the counter.
- Reset mid-squash clears the counter.

Optional Feature:
- Macro: STAGE_EX_FORWARDING_EN.
- Defined: operand A and B_reg are selected by fwdA/fwdB: 0 = register value, 1 = fwdMem, 2 = fwdWb, 3 = register value. aluSrc is then applied to the forwarded B. storeData_mem uses the forwarded B_reg.
- Undefined: fwd* ports exist but are ignored; operands come straight from reg1/reg2.

Decomposition:
- Package mips_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_LUI).
  - Forward select constants (FWD_REG, FWD_MEM, FWD_WB).
  - Data width 32.
- Sub-module: alu (combinational; inputs a, b, shamt, op; output result).

Test Plan:
- ADD, aluSrc=0, reg1=5, reg2=7 -> next cycle aluResult_mem=12, valid_mem=1. Then SUB 5-7 -> 32'hFFFFFFFE. SLT -1<1 -> 1. SLTU -> 0.
- Beq with reg1=reg2=3, pc_ex=0x100, ext=4, SQUASH_CNT=1 -> branchTaken=1 for one cycle, branchTarget=0x110. The next valid instruction gives valid_mem=0 and memWrite_mem=0.
- Bne with equal operands -> branchTaken=0, no squash. Jump with isNotConditional=1 -> taken regardless of operands.
- Stall asserted 3 cycles after a load -> outputs hold for the full 3 cycles. Branch pulse asserted in the stall cycle -> deasserted while stalled.
- Flush together with stall -> valid_mem=0, counter cleared. Reset asserted mid-squash -> all outputs 0 on the next edge.
- With STAGE_EX_FORWARDING_EN: fwdA=1, fwdMem=100, reg1=0, ADD B=1 -> 101. Without the macro, the same stimulus -> 1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared data width, ALU opcodes and forward selects for the pipeline stages.
package mips_pkg;
  localparam int DW = 32;
  typedef logic [DW-1:0] word_t;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  function automatic word_t fwd_sel(logic [1:0] sel, word_t r, word_t m, word_t w);
    return sel == FWD_MEM ? m : sel == FWD_WB ? w : r;
  endfunction
endpackage

// File: rtl/stage_ex_if.sv
// stage_ex_if: ID/EX inputs and EX/MEM outputs of the execute stage.
interface stage_ex_if;
  import mips_pkg::*;
  logic        valid_in;
  word_t       pc_ex;
  logic [3:0]  aluOp;
  logic        isJump;
  logic        isNotConditional;
  logic        isEq;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  wbi;
  logic        aluSrc;
  word_t       reg1;
  word_t       reg2;
  word_t       extendedInstr;
  logic [4:0]  regAddr1;
  logic [4:0]  regAddr2;
  logic        regDst;
  logic        stall;
  logic        flush;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  word_t       fwdMem;
  word_t       fwdWb;
  word_t       aluResult_mem;
  word_t       storeData_mem;
  logic [4:0]  writeAddr_mem;
  logic        memWrite_mem;
  logic        memRead_mem;
  logic [1:0]  wbi_mem;
  logic        valid_mem;
  logic        branchTaken;
  word_t       branchTarget;
  modport master (
    output valid_in, pc_ex, aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi,
           aluSrc, reg1, reg2, extendedInstr, regAddr1, regAddr2, regDst, stall, flush,
           fwdA, fwdB, fwdMem, fwdWb,
    input  aluResult_mem, storeData_mem, writeAddr_mem, memWrite_mem, memRead_mem, wbi_mem,
           valid_mem, branchTaken, branchTarget
  );
  modport slave (
    input  valid_in, pc_ex, aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi,
           aluSrc, reg1, reg2, extendedInstr, regAddr1, regAddr2, regDst, stall, flush,
           fwdA, fwdB, fwdMem, fwdWb,
    output aluResult_mem, storeData_mem, writeAddr_mem, memWrite_mem, memRead_mem, wbi_mem,
           valid_mem, branchTaken, branchTarget
  );
endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; opcodes 12..15 yield zero.
module alu
  import mips_pkg::*;
(
  input  word_t      a,
  input  word_t      b,
  input  logic [4:0] shamt,
  input  logic [3:0] op,
  output word_t      result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = {b[15:0], 16'h0};
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/stage_ex.sv
// stage_ex: MIPS execute stage with branch resolution and wrong-path squash; STAGE_EX_FORWARDING_EN enables operand forwarding.
module stage_ex
  import mips_pkg::*;
#(
  parameter int SQUASH_CNT = 1
) (
  input logic       clock,
  input logic       reset,
  stage_ex_if.slave ex
);
  word_t a, b_reg, b, res, target;
  logic take, eff_valid;
  logic [1:0] cnt;
`ifdef STAGE_EX_FORWARDING_EN
  assign a     = fwd_sel(ex.fwdA, ex.reg1, ex.fwdMem, ex.fwdWb);
  assign b_reg = fwd_sel(ex.fwdB, ex.reg2, ex.fwdMem, ex.fwdWb);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex.fwdA, ex.fwdB, ex.fwdMem, ex.fwdWb};
  assign a     = ex.reg1;
  assign b_reg = ex.reg2;
`endif
  assign b         = ex.aluSrc ? ex.extendedInstr : b_reg;
  assign take      = ex.isJump & (ex.isNotConditional | (ex.isEq ? a == b_reg : a != b_reg));
  assign eff_valid = ex.valid_in & (cnt == 2'd0);
  assign target    = ex.pc_ex + (ex.extendedInstr << 2);
  alu u_alu (
    .a      (a),
    .b      (b),
    .shamt  (ex.extendedInstr[10:6]),
    .op     (ex.aluOp),
    .result (res)
  );
  // Squashed slots still load the data fields; only the control bits are gated.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex.aluResult_mem <= '0;
      ex.storeData_mem <= '0;
      ex.writeAddr_mem <= '0;
      ex.memWrite_mem  <= 1'b0;
      ex.memRead_mem   <= 1'b0;
      ex.wbi_mem       <= '0;
      ex.valid_mem     <= 1'b0;
      ex.branchTaken   <= 1'b0;
      ex.branchTarget  <= '0;
      cnt              <= '0;
    end else if (ex.flush) begin
      ex.memWrite_mem <= 1'b0;
      ex.memRead_mem  <= 1'b0;
      ex.wbi_mem      <= '0;
      ex.valid_mem    <= 1'b0;
      ex.branchTaken  <= 1'b0;
      cnt             <= '0;
    end else if (ex.stall) begin
      ex.branchTaken <= 1'b0;
    end else begin
      ex.aluResult_mem <= res;
      ex.storeData_mem <= b_reg;
      ex.writeAddr_mem <= ex.regDst ? ex.regAddr2 : ex.regAddr1;
      ex.memWrite_mem  <= eff_valid & ex.memWrite;
      ex.memRead_mem   <= eff_valid & ex.memRead;
      ex.wbi_mem       <= eff_valid ? ex.wbi : 2'b0;
      ex.valid_mem     <= eff_valid;
      ex.branchTaken   <= eff_valid & take;
      ex.branchTarget  <= target;
      cnt              <= (eff_valid & take) ? 2'(SQUASH_CNT) :
                          (ex.valid_in && cnt != 2'd0) ? cnt - 2'd1 : cnt;
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: directed literal checks plus randomized traffic compared each cycle against a behavioural model.
module tb_stage_ex;
  import mips_pkg::*;
  localparam int SQ = 1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  stage_ex_if ex();
  stage_ex #(.SQUASH_CNT(SQ)) dut (.clock(clock), .reset(reset), .ex(ex));
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  word_t m_alu, m_store, m_tgt;
  logic [4:0] m_waddr;
  logic [1:0] m_wbi;
  logic m_mw, m_mr, m_valid, m_bt;
  int m_sq;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t ref_alu(logic [3:0] op, word_t a, word_t b, int sh);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b << sh;
      4'd9: return b >> sh;
      4'd10: return word_t'($signed(b) >>> sh);
      4'd11: return b * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_tick();
    word_t a, b, br;
    bit ev, take;
    if (reset) begin
      m_alu = 0; m_store = 0; m_tgt = 0; m_waddr = 0; m_wbi = 0;
      m_mw = 0; m_mr = 0; m_valid = 0; m_bt = 0; m_sq = 0;
    end else if (ex.flush) begin
      m_valid = 0; m_mw = 0; m_mr = 0; m_wbi = 0; m_bt = 0; m_sq = 0;
    end else if (ex.stall) begin
      m_bt = 0;
    end else begin
      a = ex.reg1;
      br = ex.reg2;
`ifdef STAGE_EX_FORWARDING_EN
      if (ex.fwdA == 2'd1) a = ex.fwdMem; else if (ex.fwdA == 2'd2) a = ex.fwdWb;
      if (ex.fwdB == 2'd1) br = ex.fwdMem; else if (ex.fwdB == 2'd2) br = ex.fwdWb;
`endif
      b = ex.aluSrc ? ex.extendedInstr : br;
      ev = ex.valid_in && m_sq == 0;
      take = ex.isJump && (ex.isNotConditional || (ex.isEq ? a == br : a != br));
      m_alu = ref_alu(ex.aluOp, a, b, int'(ex.extendedInstr[10:6]));
      m_store = br;
      m_waddr = ex.regDst ? ex.regAddr2 : ex.regAddr1;
      m_valid = ev;
      m_mw = ev && ex.memWrite;
      m_mr = ev && ex.memRead;
      m_wbi = ev ? ex.wbi : 2'd0;
      m_bt = ev && take;
      m_tgt = ex.pc_ex + ex.extendedInstr * 4;
      if (ev && take) m_sq = SQ;
      else if (ex.valid_in && m_sq > 0) m_sq--;
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("valid_mem", ex.valid_mem, m_valid);
      cmp("memWrite_mem", ex.memWrite_mem, m_mw);
      cmp("memRead_mem", ex.memRead_mem, m_mr);
      cmp("wbi_mem", ex.wbi_mem, m_wbi);
      cmp("branchTaken", ex.branchTaken, m_bt);
      if (m_valid) begin
        cmp("aluResult_mem", ex.aluResult_mem, m_alu);
        cmp("storeData_mem", ex.storeData_mem, m_store);
        cmp("writeAddr_mem", ex.writeAddr_mem, m_waddr);
      end
      if (m_bt) cmp("branchTarget", ex.branchTarget, m_tgt);
    end
  end

  task automatic cycle();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic idle();
    ex.valid_in = 0; ex.pc_ex = 0; ex.aluOp = 0; ex.isJump = 0; ex.isNotConditional = 0;
    ex.isEq = 0; ex.memWrite = 0; ex.memRead = 0; ex.wbi = 0; ex.aluSrc = 0; ex.reg1 = 0;
    ex.reg2 = 0; ex.extendedInstr = 0; ex.regAddr1 = 0; ex.regAddr2 = 0; ex.regDst = 0;
    ex.stall = 0; ex.flush = 0; ex.fwdA = 0; ex.fwdB = 0; ex.fwdMem = 0; ex.fwdWb = 0;
  endtask

  task automatic op(logic [3:0] o, word_t r1, word_t r2);
    idle();
    ex.valid_in = 1; ex.aluOp = o; ex.reg1 = r1; ex.reg2 = r2;
  endtask

  task automatic jump(bit uncond, bit eq, word_t r1, word_t r2);
    op(4'd0, r1, r2);
    ex.isJump = 1; ex.isNotConditional = uncond; ex.isEq = eq;
    ex.pc_ex = 32'h100; ex.extendedInstr = 32'd4;
  endtask

  initial begin
    idle();
    cycle();
    chk_en = 1;
    reset = 0;
    cmp("rst_alu", ex.aluResult_mem, 32'd0);
    cmp("rst_valid", ex.valid_mem, 32'd0);
    cmp("rst_bt", ex.branchTaken, 32'd0);
    cmp("rst_tgt", ex.branchTarget, 32'd0);
    op(4'd0, 32'd5, 32'd7); ex.regDst = 1; ex.regAddr2 = 5'd9;
    cycle();
    cmp("add_lit", ex.aluResult_mem, 32'd12);
    cmp("add_valid", ex.valid_mem, 32'd1);
    cmp("add_waddr", ex.writeAddr_mem, 32'd9);
    op(4'd1, 32'd5, 32'd7); cycle();
    cmp("sub_lit", ex.aluResult_mem, 32'hFFFFFFFE);
    op(4'd6, 32'hFFFFFFFF, 32'd1); cycle();
    cmp("slt_lit", ex.aluResult_mem, 32'd1);
    op(4'd7, 32'hFFFFFFFF, 32'd1); cycle();
    cmp("sltu_lit", ex.aluResult_mem, 32'd0);
    jump(0, 1, 32'd3, 32'd3); cycle();
    cmp("beq_bt", ex.branchTaken, 32'd1);
    cmp("beq_tgt", ex.branchTarget, 32'h110);
    op(4'd0, 32'd1, 32'd1); ex.memWrite = 1; cycle();
    cmp("squash_bt", ex.branchTaken, 32'd0);
    cmp("squash_valid", ex.valid_mem, 32'd0);
    cmp("squash_mw", ex.memWrite_mem, 32'd0);
    op(4'd0, 32'd1, 32'd1); cycle();
    cmp("post_squash_valid", ex.valid_mem, 32'd1);
    jump(0, 0, 32'd3, 32'd3); cycle();
    cmp("bne_eq_bt", ex.branchTaken, 32'd0);
    jump(1, 0, 32'd1, 32'd2); cycle();
    cmp("jump_bt", ex.branchTaken, 32'd1);
    op(4'd0, 32'd0, 32'd0); cycle();
    op(4'd0, 32'h40, 32'd0); ex.aluSrc = 1; ex.extendedInstr = 32'd8; ex.memRead = 1; ex.wbi = 2'd2;
    cycle();
    cmp("load_alu", ex.aluResult_mem, 32'h48);
    cmp("load_mr", ex.memRead_mem, 32'd1);
    op(4'd1, 32'h999, 32'd3); ex.stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      cmp("stall_alu", ex.aluResult_mem, 32'h48);
      cmp("stall_mr", ex.memRead_mem, 32'd1);
      cmp("stall_wbi", ex.wbi_mem, 32'd2);
    end
    jump(1, 0, 32'd0, 32'd0); cycle();
    cmp("pre_stall_bt", ex.branchTaken, 32'd1);
    op(4'd0, 32'd0, 32'd0); ex.stall = 1; cycle();
    cmp("stall_bt", ex.branchTaken, 32'd0);
    ex.flush = 1; cycle();
    cmp("flush_valid", ex.valid_mem, 32'd0);
    op(4'd0, 32'd2, 32'd2); cycle();
    cmp("flush_clears_cnt", ex.valid_mem, 32'd1);
    jump(1, 0, 32'd0, 32'd0); cycle();
    reset = 1; cycle(); reset = 0;
    cmp("midrst_bt", ex.branchTaken, 32'd0);
    cmp("midrst_valid", ex.valid_mem, 32'd0);
    cmp("midrst_alu", ex.aluResult_mem, 32'd0);
    op(4'd0, 32'd2, 32'd2); cycle();
    cmp("rst_clears_cnt", ex.valid_mem, 32'd1);
    op(4'd0, 32'd0, 32'd0); ex.aluSrc = 1; ex.extendedInstr = 32'd1; ex.fwdA = 2'd1; ex.fwdMem = 32'd100;
    cycle();
`ifdef STAGE_EX_FORWARDING_EN
    cmp("fwd_lit", ex.aluResult_mem, 32'd101);
`else
    cmp("fwd_lit", ex.aluResult_mem, 32'd1);
`endif
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(63) == 0);
      ex.stall = ($urandom_range(7) == 0);
      ex.flush = ($urandom_range(15) == 0);
      ex.valid_in = ($urandom_range(3) != 0);
      ex.pc_ex = $urandom; ex.aluOp = 4'($urandom); ex.isJump = ($urandom_range(3) == 0);
      ex.isNotConditional = 1'($urandom); ex.isEq = 1'($urandom);
      ex.memWrite = 1'($urandom); ex.memRead = 1'($urandom); ex.wbi = 2'($urandom);
      ex.aluSrc = 1'($urandom); ex.reg1 = $urandom;
      ex.reg2 = ($urandom_range(1) == 0) ? ex.reg1 : $urandom;
      ex.extendedInstr = $urandom; ex.regAddr1 = 5'($urandom); ex.regAddr2 = 5'($urandom);
      ex.regDst = 1'($urandom); ex.fwdA = 2'($urandom); ex.fwdB = 2'($urandom);
      ex.fwdMem = ($urandom_range(1) == 0) ? ex.reg1 : $urandom; ex.fwdWb = $urandom;
      cycle();
    end
    reset = 0;
    idle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
